// File: rtl/grover_weight_driver_pkg.sv
// Shared configuration, Q-format constants and encodings for the
// Grover weight producer and its measurement-unit partner.
package grover_weight_driver_pkg;

    localparam int NUM_QUBIT    = 4;
    localparam int WEIGHT_WIDTH = 32;
    localparam int ITER_WIDTH   = 8;

    localparam int N          = 2 ** NUM_QUBIT;
    localparam int WBUS_WIDTH = N * WEIGHT_WIDTH;
    localparam int SUM_WIDTH  = WEIGHT_WIDTH + NUM_QUBIT;
    localparam int FRAC_BITS  = WEIGHT_WIDTH - 2;

    localparam logic signed [WEIGHT_WIDTH-1:0] ONE =
        WEIGHT_WIDTH'(1) << FRAC_BITS;
    localparam logic signed [WEIGHT_WIDTH-1:0] HALF = ONE >> 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ORACLE,
        ST_SUM,
        ST_DIFFUSE,
        ST_SQUARE,
        ST_PRESENT
    } state_e;

    typedef enum logic [1:0] {
        OP_PASS,
        OP_DIFF,
        OP_SQR
    } op_e;

endpackage

// File: rtl/grover_weight_driver_amp_mac.sv
// Serial amplitude datapath: sign-extended accumulate, inversion about
// the mean, and square-with-rescale, one element per cycle.
module grover_amp_mac
    import grover_weight_driver_pkg::*;
(
    input  logic [1:0]                     op_i,
    input  logic signed [WEIGHT_WIDTH-1:0] amp_i,
    input  logic signed [SUM_WIDTH-1:0]    sum_i,
    output logic signed [SUM_WIDTH-1:0]    acc_o,
    output logic signed [WEIGHT_WIDTH-1:0] res_o
);

    logic signed [WEIGHT_WIDTH-1:0]   mean;
    logic signed [2*WEIGHT_WIDTH-1:0] prod;

    assign acc_o = sum_i + {{NUM_QUBIT{amp_i[WEIGHT_WIDTH-1]}}, amp_i};
    assign mean  = WEIGHT_WIDTH'(sum_i >>> NUM_QUBIT);
    assign prod  = amp_i * amp_i;

    always_comb begin
        res_o = amp_i;
        case (op_i)
            OP_DIFF: res_o = (mean <<< 1) - amp_i;
            OP_SQR:  res_o = WEIGHT_WIDTH'(prod >>> FRAC_BITS);
            default: res_o = amp_i;
        endcase
    end

endmodule

// File: rtl/grover_weight_driver.sv
// Grover amplitude engine: iterates oracle/diffusion, squares to a
// probability vector and holds it until the measurement unit answers.
module grover_weight_driver
    import grover_weight_driver_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  start,
    input  logic [NUM_QUBIT-1:0]  marked,
    input  logic [ITER_WIDTH-1:0] num_iter,
    output logic                  busy,
    output logic [WBUS_WIDTH-1:0] weight,
    output logic                  weight_stb,
    input  logic [NUM_QUBIT:0]    meas_out,
    input  logic                  meas_stb,
    output logic [NUM_QUBIT:0]    result,
    output logic                  result_valid
);

    localparam logic signed [WEIGHT_WIDTH-1:0] AMP_INIT =
        ONE >> (NUM_QUBIT / 2);

    state_e                         state_q, state_d;
    logic signed [WEIGHT_WIDTH-1:0] amp_q [N];
    logic signed [WEIGHT_WIDTH-1:0] amp_d [N];
    logic signed [SUM_WIDTH-1:0]    sum_q, sum_d;
    logic [NUM_QUBIT-1:0]           idx_q, idx_d;
    logic [ITER_WIDTH-1:0]          iter_q, iter_d;
    logic [NUM_QUBIT-1:0]           marked_q, marked_d;
    logic [WBUS_WIDTH-1:0]          weight_q, weight_d;
    logic                           stb_q, stb_d;
    logic [NUM_QUBIT:0]             result_q, result_d;
    logic                           rvalid_q, rvalid_d;

    logic [1:0]                     op;
    logic signed [SUM_WIDTH-1:0]    acc;
    logic signed [WEIGHT_WIDTH-1:0] res;
    logic                           last;

    assign last = (idx_q == NUM_QUBIT'(N - 1));

    grover_amp_mac u_mac (
        .op_i  (op),
        .amp_i (amp_q[idx_q]),
        .sum_i (sum_q),
        .acc_o (acc),
        .res_o (res)
    );

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q  <= ST_IDLE;
            for (int j = 0; j < N; j++) amp_q[j] <= '0;
            sum_q    <= '0;
            idx_q    <= '0;
            iter_q   <= '0;
            marked_q <= '0;
            weight_q <= '0;
            stb_q    <= 1'b0;
            result_q <= '1;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            amp_q    <= amp_d;
            sum_q    <= sum_d;
            idx_q    <= idx_d;
            iter_q   <= iter_d;
            marked_q <= marked_d;
            weight_q <= weight_d;
            stb_q    <= stb_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        amp_d    = amp_q;
        sum_d    = sum_q;
        idx_d    = idx_q;
        iter_d   = iter_q;
        marked_d = marked_q;
        weight_d = weight_q;
        stb_d    = stb_q;
        result_d = result_q;
        rvalid_d = 1'b0;
        op       = OP_PASS;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    marked_d = marked;
                    iter_d   = num_iter;
                    state_d  = ST_INIT;
                end
            end
            ST_INIT: begin
                for (int j = 0; j < N; j++) amp_d[j] = AMP_INIT;
                idx_d   = '0;
                state_d = (iter_q != '0) ? ST_ORACLE : ST_SQUARE;
            end
            ST_ORACLE: begin
                amp_d[marked_q] = -amp_q[marked_q];
                sum_d   = '0;
                idx_d   = '0;
                state_d = ST_SUM;
            end
            ST_SUM: begin
                sum_d = acc;
                idx_d = idx_q + 1'b1;
                if (last) state_d = ST_DIFFUSE;
            end
            ST_DIFFUSE: begin
                op           = OP_DIFF;
                amp_d[idx_q] = res;
                idx_d        = idx_q + 1'b1;
                if (last) begin
                    iter_d  = iter_q - 1'b1;
                    state_d = (iter_q != ITER_WIDTH'(1)) ? ST_ORACLE : ST_SQUARE;
                end
            end
            ST_SQUARE: begin
                op = OP_SQR;
                weight_d[WEIGHT_WIDTH*idx_q +: WEIGHT_WIDTH] = res;
                idx_d = idx_q + 1'b1;
                if (last) begin
                    stb_d   = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // Dropping the strobe on the capture edge stops a re-trigger.
                if (meas_stb) begin
                    result_d = meas_out;
                    rvalid_d = 1'b1;
                    stb_d    = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy         = (state_q != ST_IDLE);
    assign weight       = weight_q;
    assign weight_stb   = stb_q;
    assign result       = result_q;
    assign result_valid = rvalid_q;

endmodule

// File: tb/tb_grover_weight_driver.sv
// Bench for grover_weight_driver: directed runs plus random traffic
// compared cycle by cycle against an arithmetic Grover model.
module tb_grover_weight_driver;

    localparam int NQ = 4;
    localparam int N  = 16;
    localparam int W  = 32;
    localparam int IW = 8;

    logic           clk = 1'b0;
    logic           rstnn = 1'b1;
    logic           start = 1'b0;
    logic [NQ-1:0]  marked = '0;
    logic [IW-1:0]  num_iter = '0;
    logic           busy;
    logic [N*W-1:0] weight;
    logic           weight_stb;
    logic [NQ:0]    meas_out = '0;
    logic           meas_stb = 1'b0;
    logic [NQ:0]    result;
    logic           result_valid;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    int lat;
    logic [NQ:0] id;

    always #5 clk = ~clk;

    grover_weight_driver dut (
        .clk          (clk),
        .rstnn        (rstnn),
        .start        (start),
        .marked       (marked),
        .num_iter     (num_iter),
        .busy         (busy),
        .weight       (weight),
        .weight_stb   (weight_stb),
        .meas_out     (meas_out),
        .meas_stb     (meas_stb),
        .result       (result),
        .result_valid (result_valid)
    );

    task automatic chk(string name, logic [N*W-1:0] act, logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    bit             m_busy = 1'b0;
    bit             m_stb = 1'b0;
    bit             m_rv = 1'b0;
    logic [NQ:0]    m_result = '1;
    logic [N*W-1:0] m_weight = '0;
    logic [N*W-1:0] m_wcalc = '0;
    int             m_cnt = 0;

    function automatic void model_calc(int mk, int k);
        longint a [N];
        longint s;
        longint mean;
        for (int i = 0; i < N; i++) a[i] = longint'(1) << (W - 2 - NQ / 2);
        for (int it = 0; it < k; it++) begin
            a[mk] = -a[mk];
            s = 0;
            for (int i = 0; i < N; i++) s += a[i];
            mean = longint'(int'(s >>> NQ));
            for (int i = 0; i < N; i++) a[i] = longint'(int'(2 * mean - a[i]));
        end
        for (int i = 0; i < N; i++)
            m_wcalc[i*W +: W] = W'((a[i] * a[i]) >>> (W - 2));
    endfunction

    always @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            m_busy = 1'b0;
            m_stb = 1'b0;
            m_rv = 1'b0;
            m_result = '1;
            m_weight = '0;
            m_cnt = 0;
        end else begin
            m_rv = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_cnt = 1 + int'(num_iter) * (2 * N + 1) + N;
                    model_calc(int'(marked), int'(num_iter));
                end
            end else if (!m_stb) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_stb = 1'b1;
                    m_weight = m_wcalc;
                end
            end else if (meas_stb) begin
                m_stb = 1'b0;
                m_busy = 1'b0;
                m_result = meas_out;
                m_rv = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, m_busy);
            chk("weight_stb", weight_stb, m_stb);
            chk("result_valid", result_valid, m_rv);
            chk("result", result, m_result);
            if (!m_busy || m_stb) chk("weight", weight, m_weight);
        end
    end

    // Stand-in for the measurement unit: first index whose running sum
    // of weights exceeds the random threshold.
    function automatic logic [NQ:0] pick(logic [N*W-1:0] w, logic [W-1:0] rnd);
        longint acc;
        acc = 0;
        for (int j = 0; j < N; j++) begin
            acc += longint'(w[j*W +: W]);
            if (acc > longint'(rnd)) return 5'(j);
        end
        return 5'(N - 1);
    endfunction

    task automatic run(input int k, input int mk, input bit noise, output int l);
        @(negedge clk);
        start = 1'b1;
        marked = 4'(mk);
        num_iter = 8'(k);
        l = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = noise && (c == 8);
            if (start) begin
                marked = ~marked;
                num_iter = 8'd7;
            end
            meas_stb = noise && (c == 25) && (k > 0);
            meas_out = 5'd3;
            if (weight_stb) begin
                l = c - 1;
                break;
            end
        end
        start = 1'b0;
        meas_stb = 1'b0;
        if (l < 0) chk("stb_timeout", 0, 1);
    endtask

    task automatic measure(input logic [NQ:0] idx);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        meas_stb = 1'b1;
        meas_out = idx;
        @(negedge clk);
        meas_stb = 1'b0;
        chk("rv_pulse", result_valid, 1);
        chk("result_capture", result, idx);
        chk("stb_dropped", weight_stb, 0);
        @(negedge clk);
        chk("rv_clear", result_valid, 0);
    endtask

    initial begin
        #1 rstnn = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_stb", weight_stb, 0);
        chk("rst_result", result, 5'h1F);
        chk("rst_weight", weight, 0);
        rstnn = 1'b1;

        @(negedge clk);
        meas_stb = 1'b1;
        meas_out = 5'd2;
        @(negedge clk);
        meas_stb = 1'b0;
        chk("idle_meas_rv", result_valid, 0);
        chk("idle_meas_result", result, 5'h1F);

        run(0, 5, 1'b1, lat);
        chk("lat_k0", lat, 17);
        chk("k0_w0", weight[0 +: W], 32'h04000000);
        chk("k0_w15", weight[15*W +: W], 32'h04000000);
        measure(5'd5);

        run(1, 5, 1'b1, lat);
        chk("lat_k1", lat, 50);
        chk("k1_w5", weight[5*W +: W], 32'h1E400000);
        chk("k1_w0", weight[0 +: W], 32'h02400000);
        measure(pick(weight, 32'h30000000));

        run(3, 10, 1'b0, lat);
        chk("lat_k3", lat, 116);
        id = pick(weight, 32'h30000000);
        chk("pick_k3", id, 5'd10);
        measure(id);
        chk("result_k3", result, 5'd10);

        @(negedge clk);
        start = 1'b1;
        marked = 4'd3;
        num_iter = 8'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        #2 rstnn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_stb", weight_stb, 0);
        chk("mid_rst_rv", result_valid, 0);
        chk("mid_rst_result", result, 5'h1F);
        chk("mid_rst_weight", weight, 0);
        repeat (2) @(negedge clk);
        rstnn = 1'b1;
        run(1, 7, 1'b0, lat);
        chk("lat_after_rst", lat, 50);
        chk("rst_k1_w7", weight[7*W +: W], 32'h1E400000);
        measure(5'd7);

        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(0, 9) == 0);
            marked = 4'($urandom);
            num_iter = 8'($urandom_range(0, 3));
            meas_stb = ($urandom_range(0, 7) == 0);
            meas_out = 5'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        meas_stb = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
